// File: rtl/osd_register_bank_if.sv
// Byte-wide register bus between the i2cSlave core and the OSD register bank.
// The i2cSlave side drives address, data and strobe; the bank returns read data.
interface osd_register_bank_if;
   logic [7:0] addr;
   logic [7:0] dataIn;
   logic       writeEn;
   logic [7:0] dataOut;

   modport master (
      output addr,
      output dataIn,
      output writeEn,
      input  dataOut
   );

   modport slave (
      input  addr,
      input  dataIn,
      input  writeEn,
      output dataOut
   );
endinterface

// File: rtl/osd_register_bank.sv
// OSD register bank: paged 128-byte RAM window, control/status registers,
// user registers and a whole-RAM fill engine that owns the RAM port while busy.
module osd_register_bank #(
   parameter int         RAM_AW   = 11,
   parameter int         NUM_USER = 4,
   parameter logic [7:0] USER_RST = 8'h00
) (
   input  logic                  clk,
   input  logic                  reset_n,
   osd_register_bank_if.slave    bus,
   output logic [7:0]            ram_dataIn,
   output logic [RAM_AW-1:0]     ram_wraddress,
   output logic                  ram_wren,
   output logic                  enable_osd,
   output logic                  fill_busy,
   output logic [NUM_USER*8-1:0] user_regs
);

   localparam int PAGE_W = RAM_AW - 7;

   typedef enum logic {
      IDLE,
      FILL
   } state_t;

   state_t                     state_q;
   logic [PAGE_W-1:0]          page_q;
   logic                       ctrl_q;
   logic [7:0]                 fillval_q;
   logic                       sticky_q;
   logic [NUM_USER-1:0][7:0]   user_q;
   logic [RAM_AW-1:0]          cnt_q;
   logic [7:0]                 dout_q;
   logic [7:0]                 ram_data_q;
   logic [RAM_AW-1:0]          ram_addr_q;
   logic                       ram_wren_q;

   logic       win_hit;
   logic       sel_page;
   logic       sel_ctrl;
   logic       sel_fill;
   logic       sel_cmd;
   logic       we;
   logic [7:0] rdata_d;

   assign we       = bus.writeEn;
   assign win_hit  = ~bus.addr[7];
   assign sel_page = (bus.addr == 8'h80);
   assign sel_ctrl = (bus.addr == 8'h81);
   assign sel_fill = (bus.addr == 8'h82);
   assign sel_cmd  = (bus.addr == 8'h83);

   always_comb begin
      rdata_d = 8'h00;
      unique case (1'b1)
         sel_page: rdata_d = {{(8-PAGE_W){1'b0}}, page_q};
         sel_ctrl: rdata_d = {7'b0, ctrl_q};
         sel_fill: rdata_d = fillval_q;
         sel_cmd:  rdata_d = {6'b0, sticky_q, state_q == FILL};
         default:  ;
      endcase
      for (int i = 0; i < NUM_USER; i++) begin
         if (bus.addr == 8'(132 + i)) rdata_d = user_q[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         page_q     <= '0;
         ctrl_q     <= 1'b0;
         fillval_q  <= 8'h00;
         sticky_q   <= 1'b0;
         user_q     <= {NUM_USER{USER_RST}};
         cnt_q      <= '0;
         dout_q     <= 8'h00;
         ram_data_q <= 8'h00;
         ram_addr_q <= '0;
         ram_wren_q <= 1'b0;
      end else begin
         dout_q     <= rdata_d;
         ram_wren_q <= 1'b0;
         if (we && sel_page) page_q    <= bus.dataIn[PAGE_W-1:0];
         if (we && sel_ctrl) ctrl_q    <= bus.dataIn[0];
         if (we && sel_fill) fillval_q <= bus.dataIn;
         if (we && sel_cmd && bus.dataIn[1]) sticky_q <= 1'b0;
         for (int i = 0; i < NUM_USER; i++) begin
            if (we && bus.addr == 8'(132 + i)) user_q[i] <= bus.dataIn;
         end
         unique case (state_q)
            IDLE: begin
               if (we && sel_cmd && bus.dataIn[0]) begin
                  state_q    <= FILL;
                  ram_wren_q <= 1'b1;
                  ram_addr_q <= '0;
                  ram_data_q <= fillval_q;
                  cnt_q      <= RAM_AW'(1);
               end else if (we && win_hit) begin
                  ram_wren_q <= 1'b1;
                  ram_addr_q <= {page_q, bus.addr[6:0]};
                  ram_data_q <= bus.dataIn;
               end
            end
            FILL: begin
               // set placed after the clear so a same-cycle drop wins
               if (we && win_hit) sticky_q <= 1'b1;
               if (cnt_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  ram_wren_q <= 1'b1;
                  ram_addr_q <= cnt_q;
                  cnt_q      <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.dataOut   = dout_q;
   assign ram_dataIn    = ram_data_q;
   assign ram_wraddress = ram_addr_q;
   assign ram_wren      = ram_wren_q;
   assign enable_osd    = ctrl_q;
   assign fill_busy     = (state_q == FILL);
   assign user_regs     = user_q;

endmodule

// File: tb/tb_osd_register_bank.sv
// Directed bench for osd_register_bank: window writes, register readback,
// fill engine, drops during fill and reset during fill.
module tb_osd_register_bank;
   logic        clk;
   logic        reset_n;
   logic [7:0]  ram_dataIn;
   logic [10:0] ram_wraddress;
   logic        ram_wren;
   logic        enable_osd;
   logic        fill_busy;
   logic [31:0] user_regs;
   int          n_cmp;
   int          n_bad;

   osd_register_bank_if bus();

   osd_register_bank #(
      .RAM_AW   (11),
      .NUM_USER (4),
      .USER_RST (8'h00)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus.slave),
      .ram_dataIn    (ram_dataIn),
      .ram_wraddress (ram_wraddress),
      .ram_wren      (ram_wren),
      .enable_osd    (enable_osd),
      .fill_busy     (fill_busy),
      .user_regs     (user_regs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.addr    = a;
      bus.dataIn  = d;
      bus.writeEn = 1'b1;
      @(negedge clk);
      bus.writeEn = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.addr    = a;
      bus.writeEn = 1'b0;
      @(negedge clk);
      d = bus.dataOut;
   endtask

   task automatic test_reset();
      logic [7:0] r;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({ram_wren, fill_busy, enable_osd, ram_dataIn, ram_wraddress,
           bus.dataOut} !== 29'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got wren=%b busy=%b en=%b d=%h a=%h do=%h want all 0",
                  ram_wren, fill_busy, enable_osd, ram_dataIn, ram_wraddress, bus.dataOut);
      end
      n_cmp++;
      if (user_regs !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_user got %h want 00000000", user_regs);
      end
      reset_n = 1'b1;
      rd(8'h83, r);
      n_cmp++;
      if (r !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_stat got %h want 00", r);
      end
   endtask

   task automatic test_window();
      logic [7:0] r;
      wr(8'h80, 8'h05);
      wr(8'h12, 8'hA5);
      n_cmp++;
      if (ram_wren !== 1'b1 || ram_wraddress !== 11'h292 || ram_dataIn !== 8'hA5) begin
         n_bad++;
         $display("FAIL window_wr got wren=%b a=%h d=%h want 1 292 a5",
                  ram_wren, ram_wraddress, ram_dataIn);
      end
      @(negedge clk);
      n_cmp++;
      if (ram_wren !== 1'b0) begin
         n_bad++;
         $display("FAIL window_pulse got wren=%b want 0", ram_wren);
      end
      wr(8'h80, 8'hFF);
      rd(8'h80, r);
      n_cmp++;
      if (r !== 8'h0F) begin
         n_bad++;
         $display("FAIL page_mask got %h want 0f", r);
      end
   endtask

   task automatic test_back_to_back();
      wr(8'h80, 8'h02);
      @(negedge clk);
      bus.addr = 8'h01; bus.dataIn = 8'h11; bus.writeEn = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ram_wren !== 1'b1 || ram_wraddress !== 11'h101 || ram_dataIn !== 8'h11) begin
         n_bad++;
         $display("FAIL b2b_first got wren=%b a=%h d=%h want 1 101 11",
                  ram_wren, ram_wraddress, ram_dataIn);
      end
      bus.addr = 8'h7F; bus.dataIn = 8'h22;
      @(negedge clk);
      bus.writeEn = 1'b0;
      n_cmp++;
      if (ram_wren !== 1'b1 || ram_wraddress !== 11'h17F || ram_dataIn !== 8'h22) begin
         n_bad++;
         $display("FAIL b2b_second got wren=%b a=%h d=%h want 1 17f 22",
                  ram_wren, ram_wraddress, ram_dataIn);
      end
      @(negedge clk);
      n_cmp++;
      if (ram_wren !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_end got wren=%b want 0", ram_wren);
      end
   endtask

   task automatic test_fill();
      logic [7:0] r;
      logic [7:0] mid;
      int         bad_cyc;
      int         first_bad;
      bad_cyc   = 0;
      first_bad = -1;
      mid       = 8'hXX;
      wr(8'h82, 8'h20);
      wr(8'h83, 8'h01);
      for (int i = 0; i < 2048; i++) begin
         if (ram_wren !== 1'b1 || ram_wraddress !== 11'(i) ||
             ram_dataIn !== 8'h20 || fill_busy !== 1'b1) begin
            bad_cyc++;
            if (first_bad < 0) first_bad = i;
         end
         if (i == 401) mid = bus.dataOut;
         unique case (i)
            100: begin bus.addr = 8'h10; bus.dataIn = 8'h99; bus.writeEn = 1'b1; end
            200: begin bus.addr = 8'h82; bus.dataIn = 8'h77; bus.writeEn = 1'b1; end
            300: begin bus.addr = 8'h83; bus.dataIn = 8'h01; bus.writeEn = 1'b1; end
            400: begin bus.addr = 8'h83; bus.writeEn = 1'b0; end
            default: bus.writeEn = 1'b0;
         endcase
         @(negedge clk);
      end
      n_cmp++;
      if (bad_cyc != 0) begin
         n_bad++;
         $display("FAIL fill_seq got %0d bad cycles (first %0d) want 0", bad_cyc, first_bad);
      end
      n_cmp++;
      if (ram_wren !== 1'b0 || fill_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL fill_end got wren=%b busy=%b want 0 0", ram_wren, fill_busy);
      end
      n_cmp++;
      if (mid !== 8'h03) begin
         n_bad++;
         $display("FAIL fill_stat got %h want 03", mid);
      end
      rd(8'h82, r);
      n_cmp++;
      if (r !== 8'h77) begin
         n_bad++;
         $display("FAIL fill_fillval got %h want 77", r);
      end
      rd(8'h83, r);
      n_cmp++;
      if (r !== 8'h02) begin
         n_bad++;
         $display("FAIL sticky_after got %h want 02", r);
      end
      wr(8'h83, 8'h02);
      rd(8'h83, r);
      n_cmp++;
      if (r !== 8'h00) begin
         n_bad++;
         $display("FAIL sticky_clear got %h want 00", r);
      end
   endtask

   task automatic test_reset_mid_fill();
      logic [7:0] r;
      int         cyc;
      wr(8'h83, 8'h01);
      cyc = 0;
      while (!(ram_wren === 1'b1 && ram_wraddress === 11'h100) && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (cyc >= 4000) begin
         n_bad++;
         $display("FAIL midfill_reach got timeout want addr 100");
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (ram_wren !== 1'b0 || fill_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL midfill_abort got wren=%b busy=%b want 0 0", ram_wren, fill_busy);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (ram_wren !== 1'b0 || fill_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL midfill_idle got wren=%b busy=%b want 0 0", ram_wren, fill_busy);
      end
      rd(8'h83, r);
      n_cmp++;
      if (r !== 8'h00) begin
         n_bad++;
         $display("FAIL midfill_stat got %h want 00", r);
      end
   endtask

   task automatic test_readback();
      logic [7:0] r;
      wr(8'h81, 8'hFF);
      n_cmp++;
      if (enable_osd !== 1'b1) begin
         n_bad++;
         $display("FAIL enable_osd got %b want 1", enable_osd);
      end
      rd(8'h81, r);
      n_cmp++;
      if (r !== 8'h01) begin
         n_bad++;
         $display("FAIL ctrl_read got %h want 01", r);
      end
      wr(8'h85, 8'h3C);
      n_cmp++;
      if (user_regs !== 32'h0000_3C00) begin
         n_bad++;
         $display("FAIL user1 got %h want 00003c00", user_regs);
      end
      rd(8'h85, r);
      n_cmp++;
      if (r !== 8'h3C) begin
         n_bad++;
         $display("FAIL user1_read got %h want 3c", r);
      end
      rd(8'h90, r);
      n_cmp++;
      if (r !== 8'h00) begin
         n_bad++;
         $display("FAIL unmapped_90 got %h want 00", r);
      end
      wr(8'h88, 8'h55);
      rd(8'h88, r);
      n_cmp++;
      if (r !== 8'h00 || user_regs !== 32'h0000_3C00) begin
         n_bad++;
         $display("FAIL unmapped_88 got %h user=%h want 00 00003c00", r, user_regs);
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      bus.addr    = 8'h00;
      bus.dataIn  = 8'h00;
      bus.writeEn = 1'b0;
      test_reset();
      test_window();
      test_back_to_back();
      test_fill();
      test_reset_mid_fill();
      test_readback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
